rom_load_ctrl: RTL

Download sequencer between the HPS ioctl stream and the arcade core's ROM and configuration stores. It decodes each ioctl byte into write strobes for the main-CPU, sound-CPU and sample ROM dual-port RAMs, and latches the mod byte (index 1) and DIP bank 0 (index 254). It counts the ROM bytes received and holds the core in reset from the start of a download until a post-load settle period has elapsed. It flags a short ROM image so the game is never released on partial data.

---
 rtl/rom_load_ctrl_pkg.sv | 23 ++
 rtl/rom_load_ctrl_if.sv | 27 ++
 rtl/rom_load_ctrl_dec.sv | 35 +++
 rtl/rom_load_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rom_load_ctrl_pkg.sv
// Shared types and file-index constants for the ROM download sequencer.
package rom_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_READY,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_MAIN,
    RGN_SND,
    RGN_WAV
  } region_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// ioctl download stream in, ROM RAM write port out.
interface rom_load_ctrl_if;

  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        main_we;
  logic        snd_we;
  logic        wav_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;

  // master: HPS side feeding bytes and observing the RAM writes
  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  main_we, snd_we, wav_we, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output main_we, snd_we, wav_we, rom_addr, rom_data
  );

endinterface

// File: rtl/rom_load_ctrl_dec.sv
// Combinational map of (index, address) onto a ROM region and region-relative address.
module load_region_dec
  import rom_load_pkg::*;
#(
  parameter logic [24:0] MAIN_END = 25'h8000,
  parameter logic [24:0] SND_BASE = 25'hE000,
  parameter logic [24:0] SND_END  = 25'hF000,
  parameter logic [24:0] WAV_BASE = 25'h10000,
  parameter logic [24:0] WAV_END  = 25'h20000
) (
  input  logic [7:0]  index,
  input  logic [24:0] addr,
  output region_t     region,
  output logic [15:0] rel_addr
);

  always_comb begin
    region   = RGN_NONE;
    rel_addr = '0;
    if (index == IDX_ROM) begin
      // 16-bit subtraction is exact because every region fits in 64 KiB
      if (addr < MAIN_END) begin
        region   = RGN_MAIN;
        rel_addr = addr[15:0];
      end else if (addr >= SND_BASE && addr < SND_END) begin
        region   = RGN_SND;
        rel_addr = addr[15:0] - SND_BASE[15:0];
      end else if (addr >= WAV_BASE && addr < WAV_END) begin
        region   = RGN_WAV;
        rel_addr = addr[15:0] - WAV_BASE[15:0];
      end
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Download sequencer: decodes ioctl bytes into ROM writes/config latches and gates core reset.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [24:0] MAIN_END    = 25'h8000,
  parameter logic [24:0] SND_BASE    = 25'hE000,
  parameter logic [24:0] SND_END     = 25'hF000,
  parameter logic [24:0] WAV_BASE    = 25'h10000,
  parameter logic [24:0] WAV_END     = 25'h20000,
  parameter logic [16:0] MIN_BYTES   = 17'h9000,
  parameter int unsigned POST_CYCLES = 1024
) (
  input  logic         clk_sys,
  input  logic         reset,
  rom_load_ctrl_if.slave bus,
  output logic [7:0]   mod_code,
  output logic [7:0]   dip_sw,
  output logic [16:0]  rom_count,
  output logic         core_reset,
  output logic         load_done,
  output logic         load_error
);

  localparam int unsigned CW = (POST_CYCLES > 1) ? $clog2(POST_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(POST_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] settle_cnt, settle_nxt;
  logic          dl_q;
  logic          dl_rise, dl_fall, accept;
  region_t       region;
  logic [15:0]   rel_addr;

  logic          main_we_q, snd_we_q, wav_we_q;
  logic [15:0]   rom_addr_q;
  logic [7:0]    rom_data_q;

  load_region_dec #(
    .MAIN_END (MAIN_END),
    .SND_BASE (SND_BASE),
    .SND_END  (SND_END),
    .WAV_BASE (WAV_BASE),
    .WAV_END  (WAV_END)
  ) u_dec (
    .index    (bus.ioctl_index),
    .addr     (bus.ioctl_addr),
    .region   (region),
    .rel_addr (rel_addr)
  );

  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign dl_fall = ~bus.ioctl_download & dl_q;
  // a byte on the falling-edge cycle has download=0 and is dropped here
  assign accept  = (state == ST_LOAD) & bus.ioctl_download & bus.ioctl_wr;

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_LOAD: begin
        if (dl_fall) begin
          if (rom_count != '0 && rom_count < MIN_BYTES) begin
            state_nxt = ST_ERROR;
          end else begin
            state_nxt  = ST_SETTLE;
            settle_nxt = SETTLE_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) state_nxt = ST_READY;
        else                  settle_nxt = settle_cnt - 1'b1;
      end
      default: ;
    endcase
    if (dl_rise) state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      dl_q       <= 1'b0;
      main_we_q  <= 1'b0;
      snd_we_q   <= 1'b0;
      wav_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_count  <= '0;
      mod_code   <= '0;
      dip_sw     <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      dl_q       <= bus.ioctl_download;
      main_we_q  <= accept && region == RGN_MAIN;
      snd_we_q   <= accept && region == RGN_SND;
      wav_we_q   <= accept && region == RGN_WAV;
      if (accept && region != RGN_NONE) begin
        rom_addr_q <= rel_addr;
        rom_data_q <= bus.ioctl_dout;
      end
      if (dl_rise) begin
        rom_count <= '0;
      end else if (accept && bus.ioctl_index == IDX_ROM && rom_count != '1) begin
        rom_count <= rom_count + 1'b1;
      end
      if (accept && bus.ioctl_index == IDX_MOD) mod_code <= bus.ioctl_dout;
      if (accept && bus.ioctl_index == IDX_DIP && bus.ioctl_addr == '0) dip_sw <= bus.ioctl_dout;
    end
  end

  assign bus.main_we  = main_we_q;
  assign bus.snd_we   = snd_we_q;
  assign bus.wav_we   = wav_we_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;

  assign core_reset = (state != ST_READY);
  assign load_done  = (state == ST_READY);
  assign load_error = (state == ST_ERROR);

endmodule
